// File: rtl/mem_bank_nrw_mask.sv
// N-port masked read/write memory bank: registered reads, lowest-port-wins write arbitration, zeroing sweep after reset.
// Optional macro MEM_BANK_NRW_BYPASS_EN: same-cycle reads of a row being written return the newly written row.
module mem_bank_nrw_mask #(
  parameter int NUM_PORTS = 2,
  parameter int REG_DEPTH = 16,
  parameter int REG_WIDTH = 64,
  parameter int MASK_GRAN = 8,
  localparam int MW = REG_WIDTH / MASK_GRAN,
  localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1
) (
  input  logic                           RW_clk,
  input  logic                           RW_rst_n,
  input  logic [NUM_PORTS-1:0]           RW_en,
  input  logic [NUM_PORTS-1:0]           RW_wmode,
  input  logic [NUM_PORTS*AW-1:0]        RW_addr,
  input  logic [NUM_PORTS*MW-1:0]        RW_wmask,
  input  logic [NUM_PORTS*REG_WIDTH-1:0] RW_wdata,
  output logic [NUM_PORTS*REG_WIDTH-1:0] RW_rdata,
  output logic [NUM_PORTS-1:0]           RW_rvalid,
  output logic                           init_done,
  output logic [15:0]                    coll_cnt
);

  localparam logic [0:0]    ST_INIT  = 1'b0;
  localparam logic [0:0]    ST_RUN   = 1'b1;
  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(REG_DEPTH);
  localparam logic [AW-1:0] LAST_ROW = AW'(REG_DEPTH - 1);

  logic [0:0]           state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [REG_WIDTH-1:0] mem_q [REG_DEPTH];
  logic [REG_WIDTH-1:0] mem_d [REG_DEPTH];
  logic [REG_WIDTH-1:0] rdata_q [NUM_PORTS];
  logic [REG_WIDTH-1:0] rdata_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
  logic [15:0]          coll_cnt_q, coll_cnt_d;

  logic [AW-1:0]        port_addr  [NUM_PORTS];
  logic [MW-1:0]        port_mask  [NUM_PORTS];
  logic [REG_WIDTH-1:0] port_wdata [NUM_PORTS];
  logic [NUM_PORTS-1:0] port_ok;
  logic [NUM_PORTS-1:0] port_wr;
  logic [NUM_PORTS-1:0] port_rd;
  logic                 coll;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_addr[p]  = RW_addr[p*AW +: AW];
      port_mask[p]  = RW_wmask[p*MW +: MW];
      port_wdata[p] = RW_wdata[p*REG_WIDTH +: REG_WIDTH];
      port_ok[p]    = ({1'b0, RW_addr[p*AW +: AW]} < DEPTH_L);
      port_wr[p]    = RW_en[p] & RW_wmode[p];
      port_rd[p]    = RW_en[p] & ~RW_wmode[p];
    end
  end

  // A collision needs two in-range writers on one row sharing at least one lane.
  always_comb begin
    coll = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int q = p + 1; q < NUM_PORTS; q++) begin
        if (port_wr[p] && port_wr[q] && port_ok[p] && port_ok[q] &&
            (port_addr[p] == port_addr[q]) &&
            ((port_mask[p] & port_mask[q]) != '0)) begin
          coll = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;
    rdata_d    = rdata_q;
    rvalid_d   = '0;
    coll_cnt_d = coll_cnt_q;
    if (state_q == ST_INIT) begin
      mem_d[cnt_q] = '0;
      cnt_d        = cnt_q + AW'(1);
      if (cnt_q == LAST_ROW) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end else begin
      // Apply highest port first so lower-index ports overwrite shared lanes.
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (port_wr[p] && port_ok[p]) begin
          for (int k = 0; k < MW; k++) begin
            if (port_mask[p][k]) begin
              mem_d[port_addr[p]][k*MASK_GRAN +: MASK_GRAN] =
                port_wdata[p][k*MASK_GRAN +: MASK_GRAN];
            end
          end
        end
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (port_rd[p]) begin
          rvalid_d[p] = 1'b1;
          if (port_ok[p]) begin
`ifdef MEM_BANK_NRW_BYPASS_EN
            rdata_d[p] = mem_d[port_addr[p]];
`else
            rdata_d[p] = mem_q[port_addr[p]];
`endif
          end else begin
            rdata_d[p] = '0;
          end
        end
      end
      if (coll && (coll_cnt_q != 16'hFFFF)) begin
        coll_cnt_d = coll_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge RW_clk) begin
    if (!RW_rst_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      rdata_q    <= '{default: '0};
      rvalid_q   <= '0;
      coll_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      coll_cnt_q <= coll_cnt_d;
      mem_q      <= mem_d;
    end
  end

  always_comb begin
    RW_rdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      RW_rdata[p*REG_WIDTH +: REG_WIDTH] = rdata_q[p];
    end
  end

  assign RW_rvalid = rvalid_q;
  assign init_done = (state_q == ST_RUN);
  assign coll_cnt  = coll_cnt_q;

endmodule

// File: tb/tb_mem_bank_nrw_mask.sv
// Directed bench for mem_bank_nrw_mask (12-row instance so out-of-range addresses exist).
// A negedge monitor pops per-port expected read data whenever rvalid appears.
module tb_mem_bank_nrw_mask;

  localparam int NP    = 2;
  localparam int DEPTH = 12;
  localparam int W     = 64;
  localparam int G     = 8;
  localparam int MW    = W / G;
  localparam int AW    = 4;

`ifdef MEM_BANK_NRW_BYPASS_EN
  localparam logic [W-1:0] RDW_EXP = 64'h0000_0000_0000_1234;
`else
  localparam logic [W-1:0] RDW_EXP = 64'h0;
`endif

  // clock / reset
  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP-1:0]   en;
  logic [NP-1:0]   wmode;
  logic [NP*AW-1:0] addr;
  logic [NP*MW-1:0] wmask;
  logic [NP*W-1:0]  wdata;
  logic [NP*W-1:0]  rdata;
  logic [NP-1:0]    rvalid;
  logic             init_done;
  logic [15:0]      coll_cnt;

  always #5 clk = ~clk;

  mem_bank_nrw_mask #(
    .NUM_PORTS(NP),
    .REG_DEPTH(DEPTH),
    .REG_WIDTH(W),
    .MASK_GRAN(G)
  ) u_dut (
    .RW_clk   (clk),
    .RW_rst_n (rst_n),
    .RW_en    (en),
    .RW_wmode (wmode),
    .RW_addr  (addr),
    .RW_wmask (wmask),
    .RW_wdata (wdata),
    .RW_rdata (rdata),
    .RW_rvalid(rvalid),
    .init_done(init_done),
    .coll_cnt (coll_cnt)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [W-1:0] exp_q [NP][$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // driver tasks
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    en    = '0;
    wmode = '0;
    addr  = '0;
    wmask = '0;
    wdata = '0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [MW-1:0] m,
                    input logic [W-1:0] d);
    en[p]              = 1'b1;
    wmode[p]           = 1'b1;
    addr[p*AW +: AW]   = a;
    wmask[p*MW +: MW]  = m;
    wdata[p*W +: W]    = d;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a, input logic [W-1:0] exp);
    en[p]            = 1'b1;
    wmode[p]         = 1'b0;
    addr[p*AW +: AW] = a;
    exp_q[p].push_back(exp);
  endtask

  // scoreboard monitor: every queued read must show rvalid exactly one edge later
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (rvalid[p] === 1'b1) begin
        if (exp_q[p].size() == 0) begin
          check($sformatf("unexpected_rvalid_p%0d", p), W'(rvalid[p]), '0);
        end else begin
          check($sformatf("rdata_p%0d", p), rdata[p*W +: W], exp_q[p].pop_front());
        end
      end else if (exp_q[p].size() != 0) begin
        void'(exp_q[p].pop_front());
        check($sformatf("missing_rvalid_p%0d", p), W'(rvalid[p]), W'(1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle();
    cyc();
    cyc();
    check("reset_init_done", W'(init_done), '0);
    check("reset_coll_cnt", W'(coll_cnt), '0);
    check("reset_rvalid", W'(rvalid), '0);
    check("reset_rdata_p0", rdata[0 +: W], '0);
    check("reset_rdata_p1", rdata[W +: W], '0);

    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      cyc();
      check($sformatf("init_done_c%0d", i), W'(init_done), W'(i == DEPTH));
    end

    // every row zero after the sweep
    for (int r = 0; r < DEPTH; r++) begin
      idle();
      rd(0, AW'(r), '0);
      rd(1, AW'(DEPTH - 1 - r), '0);
      cyc();
    end

    // masked write then readback
    idle();
    wr(0, 4'd3, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc();
    idle();
    rd(1, 4'd3, 64'h0000_0000_FFFF_FFFF);
    cyc();

    // overlapping collision: lane1 shared, port0 wins
    idle();
    wr(0, 4'd5, 8'h03, {8{8'hAA}});
    wr(1, 4'd5, 8'h06, {8{8'h55}});
    cyc();
    check("coll_cnt_after_overlap", W'(coll_cnt), W'(1));

    idle();
    rd(0, 4'd5, 64'h0000_0000_0055_AAAA);
    cyc();

    // same row, disjoint masks: no collision
    idle();
    wr(0, 4'd6, 8'h01, {8{8'h11}});
    wr(1, 4'd6, 8'h02, {8{8'h22}});
    cyc();
    check("coll_cnt_after_disjoint", W'(coll_cnt), W'(1));

    // different rows, full masks: no collision
    idle();
    wr(0, 4'd8, 8'hFF, 64'h0123_4567_89AB_CDEF);
    wr(1, 4'd9, 8'hFF, 64'hFEDC_BA98_7654_3210);
    cyc();
    check("coll_cnt_after_diff_rows", W'(coll_cnt), W'(1));

    idle();
    rd(0, 4'd6, 64'h0000_0000_0000_2211);
    rd(1, 4'd9, 64'hFEDC_BA98_7654_3210);
    cyc();

    // read-during-write on row 7
    idle();
    wr(0, 4'd7, 8'hFF, 64'h0000_0000_0000_1234);
    rd(1, 4'd7, RDW_EXP);
    cyc();
    idle();
    rd(0, 4'd7, 64'h0000_0000_0000_1234);
    rd(1, 4'd8, 64'h0123_4567_89AB_CDEF);
    cyc();

    // out-of-range write dropped, out-of-range read returns zero
    idle();
    wr(0, 4'd13, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(1, 4'd14, '0);
    cyc();
    idle();
    rd(0, 4'd1, '0);
    rd(1, 4'd5, 64'h0000_0000_0055_AAAA);
    cyc();
    idle();
    cyc();
    check("rdata_hold_p1", rdata[W +: W], 64'h0000_0000_0055_AAAA);
    check("rvalid_idle", W'(rvalid), '0);

    // second collision: lane7 port0 zero wins, lane6 from port1
    idle();
    wr(0, 4'd10, 8'h80, 64'h0);
    wr(1, 4'd10, 8'hC0, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc();
    check("coll_cnt_second", W'(coll_cnt), W'(2));
    idle();
    rd(0, 4'd10, 64'h00FF_0000_0000_0000);
    cyc();

    // reset while a read is requested: no rvalid, counters cleared
    idle();
    en[0]         = 1'b1;
    wmode[0]      = 1'b0;
    addr[0 +: AW] = 4'd3;
    rst_n         = 1'b0;
    cyc();
    check("midrst_init_done", W'(init_done), '0);
    check("midrst_coll_cnt", W'(coll_cnt), '0);
    check("midrst_rvalid", W'(rvalid), '0);
    idle();
    cyc();
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      cyc();
      check($sformatf("reinit_done_c%0d", i), W'(init_done), W'(i == DEPTH));
    end
    idle();
    rd(0, 4'd3, '0);
    rd(1, 4'd10, '0);
    cyc();
    idle();
    cyc();
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mem_bank_nrw_mask.md
# mem_bank_nrw_mask

Parametrised N-port read/write memory bank with lane-granular write masks, registered reads, deterministic write-collision arbitration, and a self-clearing init sweep after reset. It is the next-generation register-file/SRAM-model bank for the memory subsystem. It replaces fixed two-port unregistered banks wherever more ports, byte-lane masking, or guaranteed post-reset contents are needed. All ports share one clock.

## Interface
- NUM_PORTS, 2, number of independent RW ports (1..8)
- REG_DEPTH, 16, number of rows (need not be a power of two)
- REG_WIDTH, 64, bits per row
- MASK_GRAN, 8, data bits per mask bit; REG_WIDTH must be a multiple of MASK_GRAN; MW = REG_WIDTH/MASK_GRAN, AW = max(1,$clog2(REG_DEPTH))
- RW_clk  in  1  clock, all logic on rising edge
- RW_rst_n  in  1  reset, synchronous, active-low
- RW_en  in  NUM_PORTS  per-port request strobe
- RW_wmode  in  NUM_PORTS  per-port 1=write, 0=read (qualified by RW_en)
- RW_addr  in  NUM_PORTS*AW  packed row addresses, port p at [p*AW +: AW]
- RW_wmask  in  NUM_PORTS*MW  packed lane masks, 1=write that lane
- RW_wdata  in  NUM_PORTS*REG_WIDTH  packed write data
- RW_rdata  out  NUM_PORTS*REG_WIDTH  packed registered read data
- RW_rvalid  out  NUM_PORTS  one-cycle pulse, RW_rdata for port p valid
- init_done  out  1  0 during init sweep, 1 when bank accepts requests
- coll_cnt  out  16  saturating count of write-collision cycles

## Operation
- FSM states: INIT, RUN. Reset enters INIT with row counter 0.
- INIT: zeroes row[cnt] each cycle, cnt increments; after row REG_DEPTH-1 written, moves to RUN next edge. All port requests ignored, no rvalid, no collisions counted.
- RUN: for each port p with RW_en[p]=1:
  - wmode=1: lane k of row addr[p] takes wdata lane k where wmask[p][k]=1; other lanes unchanged.
  - wmode=0: row contents registered into rdata[p]; rvalid[p]=1 next cycle.
- Port with RW_en=0: rdata[p] holds last value, rvalid[p]=0.
- Write-write collision: two or more writing ports, same address, overlapping lane. Lowest-index port wins that lane. Non-overlapping lanes from all ports are applied. Any such cycle increments coll_cnt by 1 (not per lane). coll_cnt saturates at 16'hFFFF.
- Same address, disjoint masks: not a collision; all lanes applied, no count.
- Out-of-range address (>= REG_DEPTH): write dropped; read returns zero with rvalid=1.
- Read-during-write, same address, same cycle: see Configuration.

## Timing
- Read latency 1 cycle: request at edge N, rdata/rvalid valid after edge N+1.
- Write visible to a read issued the following cycle.
- Full throughput: every port may issue one request every cycle in RUN.
- Init takes exactly REG_DEPTH cycles after the first edge with RW_rst_n=1. init_done rises on the edge that enters RUN. The first request is accepted in that cycle.
- Reset values: RW_rdata=0, RW_rvalid=0, init_done=0, coll_cnt=0, state=INIT, cnt=0.
- Reset mid-operation (RUN or INIT): next edge applies reset values and drops in-flight reads (no rvalid). The sweep restarts from row 0.

## Configuration
- MEM_BANK_NRW_BYPASS_EN defined: a read colliding with same-cycle writes to the same row returns the post-arbitration new row (written lanes new, others old).
- Undefined: that read returns the row contents before the cycle's writes (read-old).
- Nothing else changes; latency is identical in both builds.

## Test plan
- Reset then idle: RW_rst_n low 2 cycles, then high -> init_done=0 for 16 cycles, then 1. Reading every row returns 64'h0 with rvalid one cycle later.
- Masked write/readback: port0 writes addr 3, data 64'hFFFF_FFFF_FFFF_FFFF, mask 8'h0F. Port1 reads addr 3 next cycle -> rdata = 64'h0000_0000_FFFF_FFFF.
- Collision: port0 writes addr 5, data all 0xAA, mask 8'h03. Port1 writes addr 5, data all 0x55, mask 8'h06 -> row 5 = 64'h0000_0000_0055_AAAA; coll_cnt 0->1. Disjoint masks 8'h01/8'h02 -> coll_cnt unchanged.
- Read-during-write: row 7 = 0. Port0 writes 64'h1234 mask 8'hFF while port1 reads addr 7 -> rdata 64'h1234 with BYPASS_EN, 64'h0 without.
- Out-of-range (REG_DEPTH=12): write addr 13 dropped, no row changes. Read addr 14 -> rdata 0, rvalid 1.
- Reset mid-run: RW_rst_n low while port0 read in flight -> no rvalid; init_done=0; coll_cnt=0; previously written row 3 reads 0 after re-init.
